// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: default widths and the MEM-stage FSM state.
package mips_pkg;

  localparam int unsigned DW_DEF = 16;
  localparam int unsigned RW_DEF = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_stage_ws_data_ram.sv
// Data RAM for the MEM stage: synchronous write, asynchronous read, no reset.
module data_ram #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Single write port, written on the rising edge
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_ws.sv
// MEM pipeline stage with wait states: multi-cycle loads/stores stall EX and
// feed bubbles to WB until the access completes.
module mem_stage_ws
  import mips_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned AW      = 8,
  parameter int unsigned RW      = RW_DEF,
  parameter int unsigned ACC_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_alu_res,
  input  logic [DW-1:0] ex_store_data,
  input  logic [RW-1:0] ex_op_dest,
  input  logic          ex_mem_read,
  input  logic          ex_mem_write,
  input  logic          ex_wb_mux,
  input  logic          ex_wb_en,
  input  logic          flush,
  output logic          mem_stall,
  output logic          mem_valid,
  output logic          mem_wb_mux,
  output logic          mem_wb_en,
  output logic [RW-1:0] mem_op_dest,
  output logic [DW-1:0] mem_alu_res,
  output logic [DW-1:0] mem_mem_data
);

  // Counter preload on entering BUSY; unused when ACC_LAT is 0
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ACC_LAT - 1);

  mem_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             done;
  logic             mem_op;
  logic             ram_we;
  logic [DW-1:0]    ram_rdata;

  assign mem_op = ex_valid & (ex_mem_read | ex_mem_write);
  assign ram_we = done & mem_op & ex_mem_write;

  data_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ex_alu_res[AW-1:0]),
    .wdata (ex_store_data),
    .rdata (ram_rdata)
  );

  // Next-state, counter and stall; done marks the cycle MEM/WB takes a real op
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mem_stall = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && (ACC_LAT != 0)) begin
          mem_stall = 1'b1;
          state_n   = BUSY;
          cnt_n     = LAT_M1;
        end else begin
          done = 1'b1;
        end
      end
      BUSY: begin
        if (cnt != '0) begin
          mem_stall = 1'b1;
          cnt_n     = cnt - CNT_W'(1);
        end else begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Flush and reset abandon any access: no stall, no write, bubble next
    if (flush || rst) begin
      mem_stall = 1'b0;
      done      = 1'b0;
      state_n   = IDLE;
      cnt_n     = '0;
    end
  end

  // FSM state, wait counter and MEM/WB pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_valid    <= 1'b0;
      mem_wb_mux   <= 1'b0;
      mem_wb_en    <= 1'b0;
      mem_op_dest  <= '0;
      mem_alu_res  <= '0;
      mem_mem_data <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      mem_valid    <= done & ex_valid;
      mem_wb_en    <= done & ex_valid & ex_wb_en;
      mem_wb_mux   <= ex_wb_mux;
      mem_op_dest  <= ex_op_dest;
      mem_alu_res  <= ex_alu_res;
      if (done && mem_op && !ex_mem_write) mem_mem_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage_ws.sv
// Self-checking bench for mem_stage_ws (ACC_LAT=2 main instance, ACC_LAT=0 side instance).
module tb_mem_stage_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_wb_mux, ex_wb_en, flush;
  logic [15:0] ex_alu_res, ex_store_data;
  logic [2:0]  ex_op_dest;
  logic        mem_stall, mem_valid, mem_wb_mux, mem_wb_en;
  logic [2:0]  mem_op_dest;
  logic [15:0] mem_alu_res, mem_mem_data;

  logic        z_valid, z_rd, z_wr, z_wbm, z_wbe;
  logic [15:0] z_alu, z_sd;
  logic [2:0]  z_dest;
  logic        z_stall, z_mvalid, z_mwbm, z_mwbe;
  logic [2:0]  z_mdest;
  logic [15:0] z_malu, z_mdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage_ws #(.DW(16), .AW(8), .RW(3), .ACC_LAT(2)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_op_dest(ex_op_dest),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_wb_mux(ex_wb_mux), .ex_wb_en(ex_wb_en), .flush(flush),
    .mem_stall(mem_stall), .mem_valid(mem_valid), .mem_wb_mux(mem_wb_mux),
    .mem_wb_en(mem_wb_en), .mem_op_dest(mem_op_dest),
    .mem_alu_res(mem_alu_res), .mem_mem_data(mem_mem_data)
  );

  mem_stage_ws #(.DW(16), .AW(8), .RW(3), .ACC_LAT(0)) dut_z (
    .clk(clk), .rst(rst), .ex_valid(z_valid), .ex_alu_res(z_alu),
    .ex_store_data(z_sd), .ex_op_dest(z_dest),
    .ex_mem_read(z_rd), .ex_mem_write(z_wr),
    .ex_wb_mux(z_wbm), .ex_wb_en(z_wbe), .flush(1'b0),
    .mem_stall(z_stall), .mem_valid(z_mvalid), .mem_wb_mux(z_mwbm),
    .mem_wb_en(z_mwbe), .mem_op_dest(z_mdest),
    .mem_alu_res(z_malu), .mem_mem_data(z_mdata)
  );

  typedef struct {
    logic        v;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [2:0]  dest;
    logic        rd, wr, wbm, wbe;
    int          lat;
    logic        e_valid, e_wbe;
    logic [15:0] e_data;
    logic        chk_data;
  } vec_t;

  vec_t tbl [10];

  logic [15:0] mram   [256];
  bit          mknown [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [2:0] dest, input logic rd, input logic wr,
                       input logic wbm, input logic wbe);
    ex_valid = v; ex_alu_res = alu; ex_store_data = sd; ex_op_dest = dest;
    ex_mem_read = rd; ex_mem_write = wr; ex_wb_mux = wbm; ex_wb_en = wbe;
  endtask

  // Apply one op on the main instance and follow it to completion
  task automatic do_op(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                       input logic [2:0] dest, input logic rd, input logic wr,
                       input logic wbm, input logic wbe, input int lat,
                       input logic e_valid, input logic e_wbe,
                       input logic [15:0] e_data, input logic chk_data);
    drive(v, alu, sd, dest, rd, wr, wbm, wbe);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk("stall", 32'(mem_stall), 32'(k < lat));
      @(posedge clk); #1;
      if (k < lat) begin
        chk("bubble_valid", 32'(mem_valid), 32'd0);
        chk("bubble_wb_en", 32'(mem_wb_en), 32'd0);
      end
    end
    chk("valid", 32'(mem_valid), 32'(e_valid));
    chk("wb_en", 32'(mem_wb_en), 32'(e_wbe));
    chk("alu_res", 32'(mem_alu_res), 32'(alu));
    chk("op_dest", 32'(mem_op_dest), 32'(dest));
    chk("wb_mux", 32'(mem_wb_mux), 32'(wbm));
    if (chk_data) chk("mem_data", 32'(mem_mem_data), 32'(e_data));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_stall"}, 32'(mem_stall), 32'd0);
    chk({name, "_valid"}, 32'(mem_valid), 32'd0);
    chk({name, "_wb_en"}, 32'(mem_wb_en), 32'd0);
    chk({name, "_wb_mux"}, 32'(mem_wb_mux), 32'd0);
    chk({name, "_dest"}, 32'(mem_op_dest), 32'd0);
    chk({name, "_alu"}, 32'(mem_alu_res), 32'd0);
    chk({name, "_data"}, 32'(mem_mem_data), 32'd0);
  endtask

  // Single-cycle op on the ACC_LAT=0 instance
  task automatic z_op(input logic rd, input logic wr, input logic [15:0] alu,
                      input logic [15:0] sd, input logic [15:0] e_data, input logic chk_data);
    z_valid = 1'b1; z_rd = rd; z_wr = wr; z_alu = alu; z_sd = sd;
    z_dest = 3'd4; z_wbm = rd; z_wbe = 1'b1;
    @(negedge clk);
    chk("z_stall", 32'(z_stall), 32'd0);
    @(posedge clk); #1;
    chk("z_valid", 32'(z_mvalid), 32'd1);
    chk("z_alu", 32'(z_malu), 32'(alu));
    if (chk_data) chk("z_data", 32'(z_mdata), 32'(e_data));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] md;
    logic        mk;

    tbl[0] = '{1'b1, 16'h1234, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 16'h0107, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 16'h0000, 1'b0};
    tbl[2] = '{1'b1, 16'h0007, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 16'hBEEF, 1'b1};
    tbl[3] = '{1'b1, 16'hFF00, 16'hA5A5, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 16'hBEEF, 1'b1};
    tbl[4] = '{1'b1, 16'h0000, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 16'hA5A5, 1'b1};
    tbl[5] = '{1'b1, 16'h0007, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 16'hBEEF, 1'b1};
    tbl[6] = '{1'b0, 16'h00AA, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    tbl[7] = '{1'b1, 16'h0010, 16'h3C3C, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 16'hBEEF, 1'b1};
    tbl[8] = '{1'b1, 16'h0110, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 16'h3C3C, 1'b1};
    tbl[9] = '{1'b1, 16'h8001, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 16'h3C3C, 1'b1};

    for (int i = 0; i < 256; i++) begin mram[i] = '0; mknown[i] = 1'b0; end

    flush = 1'b0;
    z_valid = 1'b0; z_rd = 1'b0; z_wr = 1'b0; z_wbm = 1'b0; z_wbe = 1'b0;
    z_alu = '0; z_sd = '0; z_dest = '0;

    // Reset with random ex_* inputs: every output held at 0
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom));
      @(posedge clk); #1;
      @(negedge clk);
      chk_all_zero("reset");
    end
    @(posedge clk); #1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("post_reset");

    // Table-driven main cases, including address wrap and back-to-back loads
    for (int i = 0; i < 10; i++)
      do_op(tbl[i].v, tbl[i].alu, tbl[i].sd, tbl[i].dest, tbl[i].rd, tbl[i].wr,
            tbl[i].wbm, tbl[i].wbe, tbl[i].lat, tbl[i].e_valid, tbl[i].e_wbe,
            tbl[i].e_data, tbl[i].chk_data);

    // Flush in the 2nd stall cycle of a store: stall drops at once, no write
    do_op(1'b1, 16'h0003, 16'h1111, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 16'h3C3C, 1'b1);
    drive(1'b1, 16'h0003, 16'h5555, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_stall1", 32'(mem_stall), 32'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_drop", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_bubble", 32'(mem_valid), 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_idle", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    do_op(1'b1, 16'h0003, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 16'h1111, 1'b1);

    // Flush on the completion cycle still suppresses the write
    drive(1'b1, 16'h0003, 16'h6666, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_bubble", 32'(mem_valid), 32'd0);
    do_op(1'b1, 16'h0003, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 16'h1111, 1'b1);

    // Reset while BUSY abandons the pending store
    do_op(1'b1, 16'h0009, 16'h2222, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 16'h1111, 1'b1);
    drive(1'b1, 16'h0009, 16'h7777, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_busy_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_busy_valid", 32'(mem_valid), 32'd0);
    chk("rst_busy_data", 32'(mem_mem_data), 32'd0);
    @(negedge clk);
    chk("rst_busy_idle", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    do_op(1'b1, 16'h0009, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 1'b1, 16'h2222, 1'b1);

    // ACC_LAT=0 instance: store then load complete in one cycle each
    z_op(1'b0, 1'b1, 16'h0107, 16'hBEEF, 16'h0000, 1'b0);
    z_op(1'b1, 1'b0, 16'h0007, 16'h0000, 16'hBEEF, 1'b1);
    z_op(1'b0, 1'b0, 16'h4321, 16'h0000, 16'hBEEF, 1'b1);
    z_valid = 1'b0;

    // Randomized ops against a word-array reference model
    md = '0; mk = 1'b0;
    for (int n = 0; n < 200; n++) begin
      logic        v, rd, wr, wbm, wbe, memop;
      logic [15:0] alu, sd;
      logic [2:0]  dest;
      logic [7:0]  a;
      v   = ($urandom_range(0, 9) != 0);
      rd  = 1'($urandom); wr = 1'($urandom);
      wbm = 1'($urandom); wbe = 1'($urandom);
      alu = {8'($urandom), 4'h0, 4'($urandom)};
      sd  = 16'($urandom);
      dest = 3'($urandom);
      a = alu[7:0];
      memop = v && (rd || wr);
      if (memop && !wr) begin md = mram[a]; mk = mknown[a]; end
      if (memop && wr) begin mram[a] = sd; mknown[a] = 1'b1; end
      do_op(v, alu, sd, dest, rd, wr, wbm, wbe, memop ? 2 : 0, v, v && wbe, md, mk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
